// File: rtl/seq_timing_ctrl_pkg.sv
// Shared constants for the control-path timing/decode front end:
// word sizes, named timing slots and named opcode decode lines.
package seq_timing_ctrl_pkg;

    localparam int SC_WIDTH  = 4;
    localparam int OPC_WIDTH = 3;
    localparam int WORD      = 16;

    localparam int T0  = 0;
    localparam int T1  = 1;
    localparam int T2  = 2;
    localparam int T3  = 3;
    localparam int T4  = 4;
    localparam int T5  = 5;
    localparam int T6  = 6;
    localparam int T7  = 7;
    localparam int T8  = 8;
    localparam int T9  = 9;
    localparam int T10 = 10;
    localparam int T11 = 11;
    localparam int T12 = 12;
    localparam int T13 = 13;
    localparam int T14 = 14;
    localparam int T15 = 15;

    // D7 covers both register-reference and I/O instructions
    localparam int D0 = 0;
    localparam int D1 = 1;
    localparam int D2 = 2;
    localparam int D3 = 3;
    localparam int D4 = 4;
    localparam int D5 = 5;
    localparam int D6 = 6;
    localparam int D7 = 7;

    typedef enum logic [OPC_WIDTH-1:0] {
        OP_AND    = 3'd0,
        OP_ADD    = 3'd1,
        OP_LDA    = 3'd2,
        OP_STA    = 3'd3,
        OP_BUN    = 3'd4,
        OP_BSA    = 3'd5,
        OP_ISZ    = 3'd6,
        OP_REG_IO = 3'd7
    } opcode_t;

endpackage

// File: rtl/seq_timing_ctrl_onehot_dec.sv
// Generic N-to-2**N one-hot decoder with an enable that forces all lines low.
module onehot_dec #(
    parameter int N = 4
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [2**N-1:0]   y
);

    for (genvar gi = 0; gi < 2**N; gi++) begin : g_line
        assign y[gi] = en & (sel == N'(gi));
    end

endmodule

// File: rtl/seq_timing_ctrl.sv
// Sequence counter, instruction register and I/R/S flags of the basic computer,
// with one-hot timing (T) and opcode (D) decode for the register control blocks.
module seq_timing_ctrl
    import seq_timing_ctrl_pkg::*;
#(
    parameter int SC_WIDTH  = seq_timing_ctrl_pkg::SC_WIDTH,
    parameter int OPC_WIDTH = seq_timing_ctrl_pkg::OPC_WIDTH,
    parameter int WORD      = seq_timing_ctrl_pkg::WORD
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [WORD-1:0]          mem_data,
    input  logic                     SC_CLR,
    input  logic                     START,
    input  logic                     HLT,
    input  logic                     IEN,
    input  logic                     FGI,
    input  logic                     FGO,
    output logic [2**SC_WIDTH-1:0]   T,
    output logic [2**OPC_WIDTH-1:0]  D,
    output logic                     I,
    output logic                     R,
    output logic [WORD-1:0]          IR,
    output logic [SC_WIDTH-1:0]      SC,
    output logic                     S,
    output logic                     SC_WRAP
);

    logic [SC_WIDTH-1:0] sc_reg;
    logic [WORD-1:0]     ir_reg;
    logic                i_reg;
    logic                r_reg;
    logic                s_reg;
    logic                wrap_reg;

    logic                int_req;
    logic                int_done;

    onehot_dec #(.N(SC_WIDTH)) u_t_dec (
        .sel (sc_reg),
        .en  (s_reg),
        .y   (T)
    );

    // Opcode sits just below the indirect bit (IR[14:12] for a 16-bit word)
    onehot_dec #(.N(OPC_WIDTH)) u_d_dec (
        .sel (ir_reg[WORD-2 -: OPC_WIDTH]),
        .en  (1'b1),
        .y   (D)
    );

    // Interrupts are only taken outside the fetch/decode slots T0..T2
    assign int_req  = s_reg & ~T[T0] & ~T[T1] & ~T[T2] & IEN & (FGI | FGO);
    assign int_done = r_reg & T[T2];

    always_ff @(posedge clk) begin
        if (RST) begin
            sc_reg   <= '0;
            ir_reg   <= '0;
            i_reg    <= 1'b0;
            r_reg    <= 1'b0;
            s_reg    <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            if (HLT) begin
                s_reg <= 1'b0;
            end else if (START) begin
                s_reg <= 1'b1;
            end

            if (HLT) begin
                sc_reg <= '0;
            end else if (s_reg) begin
                if (SC_CLR || int_done) begin
                    sc_reg <= '0;
                end else begin
                    sc_reg <= sc_reg + 1'b1;
                    if (&sc_reg) begin
                        wrap_reg <= 1'b1;
                    end
                end
            end

            if (~r_reg & T[T1]) begin
                ir_reg <= mem_data;
            end

            if (~r_reg & T[T2]) begin
                i_reg <= ir_reg[WORD-1];
            end

            if (int_done) begin
                r_reg <= 1'b0;
            end else if (int_req) begin
                r_reg <= 1'b1;
            end
        end
    end

    assign SC      = sc_reg;
    assign IR      = ir_reg;
    assign I       = i_reg;
    assign R       = r_reg;
    assign S       = s_reg;
    assign SC_WRAP = wrap_reg;

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Directed scenarios plus a long randomized run, all checked against an
// arithmetic model of the sequencer rules kept in this bench.
module tb_seq_timing_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] mem_data;
    logic        SC_CLR;
    logic        START;
    logic        HLT;
    logic        IEN;
    logic        FGI;
    logic        FGO;
    logic [15:0] T;
    logic [7:0]  D;
    logic        I;
    logic        R;
    logic [15:0] IR;
    logic [3:0]  SC;
    logic        S;
    logic        SC_WRAP;

    int checks   = 0;
    int failures = 0;

    // Reference state: count as a plain integer, flags as bits
    int          m_sc;
    logic        m_s;
    logic        m_r;
    logic        m_i;
    logic        m_wrap;
    logic [15:0] m_ir;

    always #5 clk = ~clk;

    seq_timing_ctrl dut (
        .clk      (clk),
        .RST      (RST),
        .mem_data (mem_data),
        .SC_CLR   (SC_CLR),
        .START    (START),
        .HLT      (HLT),
        .IEN      (IEN),
        .FGI      (FGI),
        .FGO      (FGO),
        .T        (T),
        .D        (D),
        .I        (I),
        .R        (R),
        .IR       (IR),
        .SC       (SC),
        .S        (S),
        .SC_WRAP  (SC_WRAP)
    );

    task automatic model_edge();
        int          slot;
        int          n_sc;
        logic        n_s, n_r, n_i, n_wrap;
        logic [15:0] n_ir;
        if (RST) begin
            m_sc = 0; m_s = 0; m_r = 0; m_i = 0; m_wrap = 0; m_ir = 16'h0000;
            return;
        end
        slot   = m_s ? m_sc : -1;
        n_s    = HLT ? 1'b0 : (START ? 1'b1 : m_s);
        n_sc   = m_sc;
        n_wrap = m_wrap;
        if (HLT) n_sc = 0;
        else if (m_s) begin
            if (SC_CLR || (m_r && slot == 2)) n_sc = 0;
            else begin
                n_sc = (m_sc + 1) % 16;
                if (m_sc == 15) n_wrap = 1'b1;
            end
        end
        n_ir = (slot == 1 && !m_r) ? mem_data : m_ir;
        n_i  = (slot == 2 && !m_r) ? m_ir[15] : m_i;
        n_r  = m_r;
        if (m_r && slot == 2) n_r = 1'b0;
        else if (slot >= 3 && IEN && (FGI || FGO)) n_r = 1'b1;
        m_sc = n_sc; m_s = n_s; m_r = n_r; m_i = n_i; m_ir = n_ir; m_wrap = n_wrap;
    endtask

    function automatic logic [47:0] exp_vec();
        logic [15:0] et;
        logic [7:0]  ed;
        logic [2:0]  op;
        et = m_s ? (16'd1 << m_sc) : 16'd0;
        op = m_ir[14:12];
        ed = 8'd1 << op;
        return {et, ed, m_i, m_r, m_ir, 4'(m_sc), m_s, m_wrap};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        RST = 0; SC_CLR = 0; START = 0; HLT = 0; IEN = 0; FGI = 0; FGO = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_data = 16'h5A5A;
        RST = 1; START = 1;
        tick(); tick();
        checks++; if (T !== 16'h0000)  begin failures++; $display("FAIL reset_T: got %h expected %h", T, 16'h0000); end
        checks++; if (D !== 8'h01)     begin failures++; $display("FAIL reset_D: got %h expected %h", D, 8'h01); end
        checks++; if (S !== 1'b0)      begin failures++; $display("FAIL reset_S: got %b expected 0", S); end
        checks++; if (SC !== 4'd0)     begin failures++; $display("FAIL reset_SC: got %0d expected 0", SC); end
        checks++; if (R !== 1'b0)      begin failures++; $display("FAIL reset_R: got %b expected 0", R); end
        checks++; if (SC_WRAP !== 1'b0) begin failures++; $display("FAIL reset_wrap: got %b expected 0", SC_WRAP); end
        checks++; if (IR !== 16'h0000 || I !== 1'b0) begin failures++; $display("FAIL reset_IR_I: got IR=%h I=%b expected 0000/0", IR, I); end
        idle_inputs();
        $display("test_reset done");
    endtask

    task automatic test_fetch();
        mem_data = 16'hA123;
        START = 1;
        tick();
        checks++; if (T !== 16'h0001) begin failures++; $display("FAIL fetch_T0: got %h expected %h", T, 16'h0001); end
        tick();                     // START still high while running: no effect
        START = 0;
        checks++; if (T !== 16'h0002) begin failures++; $display("FAIL fetch_T1: got %h expected %h", T, 16'h0002); end
        tick();
        checks++; if (T !== 16'h0004) begin failures++; $display("FAIL fetch_T2: got %h expected %h", T, 16'h0004); end
        checks++; if (IR !== 16'hA123) begin failures++; $display("FAIL fetch_IR: got %h expected %h", IR, 16'hA123); end
        checks++; if (D !== 8'h04)    begin failures++; $display("FAIL fetch_D: got %h expected %h", D, 8'h04); end
        tick();
        checks++; if (T !== 16'h0008) begin failures++; $display("FAIL fetch_T3: got %h expected %h", T, 16'h0008); end
        checks++; if (I !== 1'b1)     begin failures++; $display("FAIL fetch_I: got %b expected 1", I); end
        $display("test_fetch done");
    endtask

    task automatic test_sc_clr();
        tick(); tick();
        checks++; if (T !== 16'h0020) begin failures++; $display("FAIL clr_T5: got %h expected %h", T, 16'h0020); end
        SC_CLR = 1;
        tick();
        checks++; if (T !== 16'h0001) begin failures++; $display("FAIL clr_to_T0: got %h expected %h", T, 16'h0001); end
        tick();
        checks++; if (T !== 16'h0001) begin failures++; $display("FAIL clr_hold_T0: got %h expected %h", T, 16'h0001); end
        tick(); tick();             // hold at T0, then walk forward
        SC_CLR = 0;
        tick(); tick();
        SC_CLR = 1; HLT = 1;
        tick();
        SC_CLR = 0; HLT = 0;
        checks++; if (S !== 1'b0 || T !== 16'h0000 || SC !== 4'd0) begin
            failures++; $display("FAIL clr_hlt: got S=%b T=%h SC=%0d expected 0/0000/0", S, T, SC);
        end
        $display("test_sc_clr done");
    endtask

    task automatic test_interrupt();
        mem_data = 16'h7001;
        START = 1;
        tick();
        START = 0;
        tick(); tick(); tick(); tick();
        checks++; if (T !== 16'h0010) begin failures++; $display("FAIL int_T4: got %h expected %h", T, 16'h0010); end
        IEN = 1; FGI = 1; SC_CLR = 1;
        tick();
        IEN = 0; FGI = 0; SC_CLR = 0;
        mem_data = 16'hFFFF;
        checks++; if (R !== 1'b1 || SC !== 4'd0) begin failures++; $display("FAIL int_set: got R=%b SC=%0d expected 1/0", R, SC); end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++; if (R !== 1'b1 || T !== (16'd1 << k) || IR !== 16'h7001) begin
                failures++; $display("FAIL int_RT%0d: got R=%b T=%h IR=%h expected 1/%h/7001", k, R, T, IR, 16'd1 << k);
            end
        end
        tick();
        checks++; if (R !== 1'b0 || SC !== 4'd0 || IR !== 16'h7001 || I !== 1'b0) begin
            failures++; $display("FAIL int_done: got R=%b SC=%0d IR=%h I=%b expected 0/0/7001/0", R, SC, IR, I);
        end
        $display("test_interrupt done");
    endtask

    task automatic test_int_gate();
        IEN = 1; FGO = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (R !== 1'b0) begin failures++; $display("FAIL gate_T%0d: got R=%b expected 0", k, R); end
        end
        IEN = 0; FGO = 0;
        checks++; if (SC !== 4'd3) begin failures++; $display("FAIL gate_SC: got %0d expected 3", SC); end
        $display("test_int_gate done");
    endtask

    task automatic test_wrap();
        RST = 1;
        tick();
        RST = 0; START = 1;
        tick();
        START = 0;
        for (int k = 1; k <= 15; k++) tick();
        checks++; if (SC !== 4'd15 || SC_WRAP !== 1'b0) begin failures++; $display("FAIL wrap_pre: got SC=%0d wrap=%b expected 15/0", SC, SC_WRAP); end
        tick();
        checks++; if (SC !== 4'd0 || SC_WRAP !== 1'b1) begin failures++; $display("FAIL wrap_set: got SC=%0d wrap=%b expected 0/1", SC, SC_WRAP); end
        HLT = 1;
        tick(); tick();
        HLT = 0;
        checks++; if (SC_WRAP !== 1'b1) begin failures++; $display("FAIL wrap_sticky: got %b expected 1", SC_WRAP); end
        RST = 1;
        tick();
        RST = 0;
        checks++; if (SC_WRAP !== 1'b0) begin failures++; $display("FAIL wrap_rst: got %b expected 0", SC_WRAP); end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        logic [47:0] got;
        int          bad = 0;
        for (int n = 0; n < 3000; n++) begin
            RST      = ($urandom_range(0, 99) == 0);
            START    = ($urandom_range(0, 7) == 0);
            HLT      = ($urandom_range(0, 39) == 0);
            SC_CLR   = ($urandom_range(0, 9) == 0);
            IEN      = $urandom_range(0, 1) != 0;
            FGI      = ($urandom_range(0, 5) == 0);
            FGO      = ($urandom_range(0, 5) == 0);
            mem_data = 16'($urandom);
            tick();
            got = {T, D, I, R, IR, SC, S, SC_WRAP};
            checks++;
            if (got !== exp_vec()) begin
                failures++; bad++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, got, exp_vec());
            end
        end
        idle_inputs();
        $display("test_random done: %0d cycles, %0d bad", 3000, bad);
    endtask

    initial begin
        idle_inputs();
        mem_data = 16'h0000;
        test_reset();
        test_fetch();
        test_sc_clr();
        test_interrupt();
        test_int_gate();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
